mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 tb/tb_mem_wb_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: multi-cycle data memory, branch select, stall and writeback capture.
// Optional address range checking is enabled by defining MEM_RANGE_CHECK_EN.
module mem_wb_stage #(
    parameter int MEM_DEPTH   = 512,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_LSB    = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic        BranchM,
    input  logic        ZeroM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        PCSrcM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic        MemErr
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        mem [MEM_DEPTH];
    logic               access;
    logic               complete;
    logic               stall;
    logic               range_err;
    logic [IDX_W-1:0]   idx;

    assign access = MemtoRegM | MemWriteM;
    assign idx    = ALUOutM[ADDR_LSB+IDX_W-1:ADDR_LSB];

`ifdef MEM_RANGE_CHECK_EN
    assign range_err = access & (|ALUOutM[31:ADDR_LSB+IDX_W]);
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        complete   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (access) begin
                    if (MEM_LATENCY > 1) begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                        stall      = 1'b1;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Reset must silence the stall request immediately, not just at the next edge.
    assign StallM  = stall & ~RESET;
    assign PCSrcM  = BranchM & ZeroM;
    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            WriteRegW <= '0;
            ALUOutW   <= '0;
            ReadDataW <= '0;
            MemErr    <= 1'b0;
        end else begin
            if (stall) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                WriteRegW <= '0;
            end else begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= MemtoRegM;
                WriteRegW <= WriteRegM;
                ALUOutW   <= ALUOutM;
            end
            // Read sees the pre-store word, so a combined load+store returns the old value.
            if (complete && MemtoRegM)
                ReadDataW <= range_err ? 32'd0 : mem[idx];
            if (complete && range_err)
                MemErr <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (complete && MemWriteM && !range_err && !RESET)
            mem[idx] <= WriteDataM;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes model results, monitor pops at each non-stalled edge.
module tb_mem_wb_stage;
    localparam int LAT = 2;

    logic        CLOCK;
    logic        RESET;
    logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        PCSrcM, StallM, RegWriteW, MemtoRegW, MemErr;
    logic [31:0] ReadDataW, ALUOutW, ResultW;
    logic [4:0]  WriteRegW;

    mem_wb_stage #(.MEM_DEPTH(512), .MEM_LATENCY(LAT), .ADDR_LSB(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchM(BranchM), .ZeroM(ZeroM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .PCSrcM(PCSrcM), .StallM(StallM), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WriteRegW(WriteRegW), .ResultW(ResultW), .MemErr(MemErr)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_txn = 0;
    logic         mon_en = 1'b0;
    // Layout: {rw, m2r, wr[4:0], alu[31:0], rd[31:0], result[31:0], err}
    logic [103:0] exp_q[$];
    logic [103:0] last_e = '0;
    logic [31:0]  ref_mem [512];
    logic [31:0]  model_rd = '0;
    logic         model_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic drive(input logic rw, m2r, mw, br, z, input logic [31:0] alu, wd, input logic [4:0] wr);
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw; BranchM = br; ZeroM = z;
        ALUOutM = alu; WriteDataM = wd; WriteRegM = wr;
    endtask

    task automatic issue(input logic rw, m2r, mw, br, z, input logic [31:0] alu, wd, input logic [4:0] wr);
        int   widx;
        int   stalls;
        int   exp_st;
        logic bad;
        logic [31:0] res;
        @(negedge CLOCK);
        drive(rw, m2r, mw, br, z, alu, wd, wr);
        mon_en = 1'b1;
        // Reference: word memory, wrap modulo depth unless range checking flags the access.
        widx = int'((alu >> 2) % 32'd512);
        bad  = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
        bad = (m2r | mw) && ((alu >> 2) >= 32'd512);
`endif
        if (m2r) model_rd = bad ? 32'd0 : ref_mem[widx];
        if (mw && !bad) ref_mem[widx] = wd;
        if (bad) model_err = 1'b1;
        res = m2r ? model_rd : alu;
        exp_q.push_back({rw, m2r, wr, alu, model_rd, res, model_err});
        exp_st = (m2r | mw) ? LAT - 1 : 0;
        #2;
        chk("pcsrc", 128'(PCSrcM), 128'(br & z));
        stalls = 0;
        while (StallM && stalls < 20) begin
            stalls++;
            @(negedge CLOCK);
            #2;
        end
        chk("stall_cycles", 128'(stalls), 128'(exp_st));
    endtask

    // Monitor: each edge is either a stall bubble or the retirement of the oldest instruction.
    initial begin
        logic         act;
        logic         stall_pre;
        logic [103:0] act_v;
        logic [103:0] e;
        forever begin
            @(negedge CLOCK);
            #2;
            act       = mon_en;
            stall_pre = StallM;
            @(posedge CLOCK);
            #1;
            if (act) begin
                act_v = {RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW, ResultW, MemErr};
                if (stall_pre) begin
                    chk("bubble", 128'(act_v), 128'({7'd0, last_e[96:33], last_e[96:65], last_e[0]}));
                end else if (exp_q.size() == 0) begin
                    chk("queue_nonempty", 128'(0), 128'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_txn", 128'(act_v), 128'(e));
                    last_e = e;
                    n_txn++;
                    $display("txn %0d: rw=%0b m2r=%0b wr=%0d alu=%h result=%h err=%0b",
                             n_txn, RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ResultW, MemErr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          k;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        #12;
        chk("reset_state", 128'({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, StallM, MemErr}), 128'(0));
        RESET = 1'b0;

        for (int i = 0; i < 16; i++) issue(0, 0, 1, 0, 0, 32'(i * 4), $urandom, 5'd0);

        issue(0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(1, 1, 0, 0, 0, 32'h10, 32'd0, 5'd8);
        issue(1, 0, 0, 0, 0, 32'h1234, 32'd0, 5'd3);
        issue(0, 0, 0, 1, 1, 32'h0, 32'd0, 5'd0);
        issue(0, 0, 0, 1, 0, 32'h4, 32'd0, 5'd0);

        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 4));
            a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 11);
            case (k)
                0: issue(0, 0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
                1: issue(1'($urandom), 0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
                2: issue(0, 0, 1, 0, 0, a, $urandom, 5'($urandom));
                3: issue(1'($urandom), 1, 0, 0, 0, a, $urandom, 5'($urandom));
                default: issue(1, 1, 1, 0, 0, a, $urandom, 5'($urandom));
            endcase
        end

        // Abandon a store with a mid-access reset pulse.
        issue(0, 0, 1, 0, 0, 32'h20, 32'h11111111, 5'd0);
        @(negedge CLOCK);
        mon_en = 1'b0;
        drive(0, 0, 1, 0, 0, 32'h20, 32'h55, 5'd0);
        @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        #1;
        chk("reset_mid_wait", 128'({RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, StallM, MemErr}), 128'(0));
        RESET = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        exp_q.delete();
        model_rd  = '0;
        model_err = 1'b0;
        last_e    = '0;
        issue(1, 1, 0, 0, 0, 32'h20, 32'd0, 5'd9);

        // Out-of-range load: wraps in the default build, flagged when range checking is on.
        issue(0, 0, 1, 0, 0, 32'h10, 32'hA5A5A5A5, 5'd0);
        issue(1, 1, 0, 0, 0, 32'h810, 32'd0, 5'd4);
        issue(1, 0, 0, 0, 0, 32'h77, 32'd0, 5'd5);

        @(negedge CLOCK);
        mon_en = 1'b0;
        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 5'd0);
        #5;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
